// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: unsigned binary score to packed BCD digits,
// with a leading-zero blank mask and saturation on overflow for a 7-segment driver.
module bin2bcd_seq #(
   parameter int BIN_W  = 27,
   parameter int DIGITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BIN_W-1:0]    in_bin,
   output logic                out_valid,
   output logic [4*DIGITS-1:0] bcd,
   output logic [DIGITS-1:0]   blank,
   output logic                overflow
);

   localparam int INT_D = (BIN_W * 301) / 1000 + 1;
   localparam int ACC_W = 4 * INT_D;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic {IDLE, CONV} state_t;

   state_t              state;
   logic [BIN_W-1:0]    shift_q;
   logic [ACC_W-1:0]    acc_q;
   logic [CNT_W-1:0]    cnt_q;

   logic [ACC_W-1:0]    acc_adj;
   logic [ACC_W-1:0]    acc_next;
   logic [4*DIGITS-1:0] bcd_next;
   logic [DIGITS-1:0]   blank_next;
   logic                ovf_next;
   logic                zero_above;

   // Add-3 correction followed by the shift; the result is what the accumulator
   // holds after this step, so the final step can register it directly.
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment,
      // otherwise the unassigned paths would infer latches.
      acc_adj    = acc_q;
      bcd_next   = '0;
      blank_next = '0;
      zero_above = 1'b1;
      for (int d = 0; d < INT_D; d++) begin
         if (acc_q[4*d +: 4] >= 4'd5)
            acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
      acc_next = {acc_adj[ACC_W-2:0], shift_q[BIN_W-1]};
      ovf_next = |acc_next[ACC_W-1:4*DIGITS];
      for (int d = DIGITS - 1; d >= 1; d--) begin
         zero_above    = zero_above & (acc_next[4*d +: 4] == 4'd0);
         blank_next[d] = zero_above;
      end
      if (ovf_next) begin
         bcd_next   = {DIGITS{4'h9}};
         blank_next = '0;
      end else begin
         bcd_next   = acc_next[4*DIGITS-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         bcd       <= '0;
         blank     <= {{(DIGITS-1){1'b1}}, 1'b0};
         overflow  <= 1'b0;
         shift_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  shift_q  <= in_bin;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state    <= CONV;
                  in_ready <= 1'b0;
               end
            end
            CONV: begin
               acc_q   <= acc_next;
               shift_q <= {shift_q[BIN_W-2:0], 1'b0};
               cnt_q   <= cnt_q + CNT_W'(1);
               // Last shift: publish the result and reopen the input together.
               if (cnt_q == CNT_W'(BIN_W - 1)) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b1;
                  bcd       <= bcd_next;
                  blank     <= blank_next;
                  overflow  <= ovf_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: an arithmetic reference model checked every cycle, plus
// directed conversions with literal expected digits, masks and latencies.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [26:0] in_bin = '0;
   logic        out_valid;
   logic [31:0] bcd;
   logic [7:0]  blank;
   logic        overflow;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   bin2bcd_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_bin(in_bin), .out_valid(out_valid), .bcd(bcd), .blank(blank),
      .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: decimal digits by division, saturation above 8 digits.
   function automatic void model(input int unsigned v, output logic [31:0] b,
                                 output logic [7:0] bl, output logic o);
      longint unsigned p = 1;
      o  = (v > 99999999);
      b  = '0;
      bl = '0;
      for (int i = 0; i < 8; i++) begin
         b[4*i +: 4] = 4'((longint'(v) / p) % 10);
         if (i >= 1 && longint'(v) < p) bl[i] = 1'b1;
         p = p * 10;
      end
      if (o) begin
         b  = 32'h9999_9999;
         bl = '0;
      end
   endfunction

   // Model state: busy flag, steps since accept, held expected outputs.
   bit          m_busy = 0;
   int          m_cnt = 0;
   int unsigned m_val = 0;
   logic        exp_ready = 1'b1;
   logic        exp_ov = 1'b0;
   logic [31:0] exp_bcd = '0;
   logic [7:0]  exp_blank = 8'hFE;
   logic        exp_ovf = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         m_busy = 0; m_cnt = 0; exp_ready = 1'b1; exp_ov = 1'b0;
         exp_bcd = '0; exp_blank = 8'hFE; exp_ovf = 1'b0;
      end
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("bcd", bcd, exp_bcd);
      check("blank", 32'(blank), 32'(exp_blank));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      if (rst) begin
         exp_ov = 1'b0;
         if (m_busy) begin
            m_cnt++;
            if (m_cnt == 27) begin
               m_busy = 0;
               model(m_val, exp_bcd, exp_blank, exp_ovf);
               exp_ov = 1'b1;
            end
         end else if (in_valid) begin
            m_busy = 1;
            m_cnt  = 0;
            m_val  = 32'(in_bin);
         end
         exp_ready = !m_busy;
      end
   end

   task automatic wait_done(output int at_cyc);
      bit seen = 0;
      at_cyc = -1;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            seen   = 1;
            at_cyc = cyc;
         end
      end
      if (!seen) check("out_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_conv(input string name, input int unsigned v, input logic [31:0] eb,
                           input logic [7:0] ebl, input logic eo, input bit disturb);
      int t0, t1;
      @(posedge clk); #2;
      in_valid = 1'b1;
      in_bin   = 27'(v);
      @(posedge clk); #2;
      t0 = cyc;
      in_valid = 1'b0;
      if (disturb) begin
         repeat (5) @(posedge clk);
         #2 in_bin = 27'd999;
         in_valid = 1'b1;
         repeat (2) @(posedge clk);
         #2 in_valid = 1'b0;
      end
      wait_done(t1);
      check({name, "_latency"}, 32'(t1 - t0), 32'd27);
      check({name, "_bcd"}, bcd, eb);
      check({name, "_blank"}, 32'(blank), 32'(ebl));
      check({name, "_ovf"}, 32'(overflow), 32'(eo));
      @(posedge clk); #2;
   endtask

   initial begin
      int t0, t1, t2, pulses;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;

      run_conv("zero", 0, 32'h0000_0000, 8'hFE, 1'b0, 0);
      run_conv("mixed", 12345678, 32'h1234_5678, 8'h00, 1'b0, 0);
      run_conv("max8", 99999999, 32'h9999_9999, 8'h00, 1'b0, 0);
      run_conv("ovf1e8", 100000000, 32'h9999_9999, 8'h00, 1'b1, 0);
      run_conv("ovfmax", 134217727, 32'h9999_9999, 8'h00, 1'b1, 0);
      run_conv("busy42", 42, 32'h0000_0042, 8'hFC, 1'b0, 1);
      run_conv("one", 1, 32'h0000_0001, 8'hFE, 1'b0, 0);
      run_conv("tens", 10, 32'h0000_0010, 8'hFC, 1'b0, 0);

      // Back-to-back with in_valid held high.
      @(posedge clk); #2;
      in_valid = 1'b1;
      in_bin   = 27'd7;
      @(posedge clk); #2;
      t0 = cyc;
      in_bin = 27'd305;
      wait_done(t1);
      check("b2b_first_bcd", bcd, 32'h0000_0007);
      check("b2b_first_latency", 32'(t1 - t0), 32'd27);
      @(posedge clk); #2;
      in_valid = 1'b0;
      wait_done(t2);
      check("b2b_second_bcd", bcd, 32'h0000_0305);
      check("b2b_second_blank", 32'(blank), 32'h0000_00F8);
      check("b2b_spacing", 32'(t2 - t0), 32'd55);
      @(posedge clk); #2;

      // Reset mid-conversion.
      in_valid = 1'b1;
      in_bin   = 27'd555;
      @(posedge clk); #2;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_bcd", bcd, 32'h0);
      check("rst_blank", 32'(blank), 32'h0000_00FE);
      check("rst_ovf", 32'(overflow), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) pulses++;
      end
      check("aborted_no_pulse", 32'(pulses), 32'd0);
      run_conv("after_rst", 555, 32'h0000_0555, 8'hF8, 1'b0, 0);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
